// File: rtl/arb_pkg.sv
// Shared types and defaults for the N-way round-robin arbiter.
// Holds state encodings, default sizes and the index-width helper.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Width needed to index n items; never below one bit.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbiter_rr_ctrl_if.sv
// Requester/arbiter bundle: request, grant and owner status.
// Optional lock line present only when ARB_LOCK_EN is defined.
interface arbiter_rr_ctrl_if
    import arb_pkg::*;
#(
    parameter int N = DEF_N
);
    localparam int IDW = idw(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [IDW-1:0] owner_id;
`ifdef ARB_LOCK_EN
    logic           lock;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  busy,
        input  owner_id
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output busy,
        output owner_id
    );
`else
    modport master (
        output req,
        input  gnt,
        input  busy,
        input  owner_id
    );

    modport slave (
        input  req,
        output gnt,
        output busy,
        output owner_id
    );
`endif

endinterface

// File: rtl/rr_pick.sv
// Circular first-set search over req, starting at ptr.
// Purely combinational; found is low when req is all zero.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N   = DEF_N,
    localparam int IDW = idw(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    // Scan offsets high to low so the closest set bit wins last.
    always_comb begin
        int j;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_ctrl.sv
// N-way round-robin arbiter with bounded hold and owner-ID output.
// Define ARB_LOCK_EN to add a lock input that suppresses forced release.
module arbiter_rr_ctrl
    import arb_pkg::*;
#(
    parameter  int N        = DEF_N,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IDW      = idw(N),
    localparam int HCW      = idw(MAX_HOLD)
) (
    input logic               clock,
    input logic               reset,
    arbiter_rr_ctrl_if.slave  bus
);

    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HCW-1:0] hold_q, hold_d;

    logic           found;
    logic [IDW-1:0] pick_idx;
    logic           lock_w;
    logic           others;
    logic           own_req;

`ifdef ARB_LOCK_EN
    assign lock_w = bus.lock;
`else
    assign lock_w = 1'b0;
`endif

    assign own_req = |(bus.req & gnt_q);
    assign others  = |(bus.req & ~gnt_q);

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    // Grant FSM next state: pick in IDLE, keep or release in GRANT.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d         = ST_GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    busy_d          = 1'b1;
                    hold_d          = '0;
                end
            end
            ST_GRANT: begin
                if (!own_req ||
                    (hold_q == HOLD_MAX && others && !lock_w)) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    owner_d  = '0;
                    busy_d   = 1'b0;
                    hold_d   = '0;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0
                             : owner_q + IDW'(1);
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;
    assign bus.owner_id = owner_q;

endmodule

// File: tb/tb_arbiter_rr_ctrl.sv
// Directed bench for arbiter_rr_ctrl (N=4, MAX_HOLD=8).
// Lock scenario is included when ARB_LOCK_EN is defined.
module tb_arbiter_rr_ctrl;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    arbiter_rr_ctrl_if #(.N(4)) bus ();

    arbiter_rr_ctrl #(.N(4), .MAX_HOLD(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] g,
                       input logic [1:0] id, input logic b);
        total++;
        if (bus.gnt !== g || bus.owner_id !== id || bus.busy !== b) begin
            bad++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b want gnt=%b id=%0d busy=%b",
                     nm, bus.gnt, bus.owner_id, bus.busy, g, id, b);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bus.req = 4'b0000;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bus.req = 4'b0000;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        #2;
        chk("reset_state", 4'b0000, 2'd0, 1'b0);
        #5;
        reset = 1'b1;
        step();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0);
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        step();
        chk("single_grant", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b0000;
        step();
        chk("single_release", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b1111;
        step();
        chk("ptr_after_2", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        int o;
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            o = k % 4;
            for (int c = 0; c < 3; c++) begin
                step();
                if (bus.gnt !== (4'b0001 << o) || bus.owner_id !== 2'(o)) begin
                    bad++;
                    $display("FAIL rr_grant k=%0d c=%0d: gnt=%b id=%0d want owner %0d",
                             k, c, bus.gnt, bus.owner_id, o);
                end
                total++;
            end
            bus.req[o] = 1'b0;
            step();
            chk("rr_dead_cycle", 4'b0000, 2'd0, 1'b0);
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_hold_timeout();
        logic [3:0] exp_g;
        do_reset();
        bus.req = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            exp_g = (r == 1) ? 4'b0010 : 4'b0001;
            for (int c = 0; c < 8; c++) begin
                step();
                chk("hold_owner", exp_g, (r == 1) ? 2'd1 : 2'd0, 1'b1);
            end
            step();
            chk("hold_forced_rel", 4'b0000, 2'd0, 1'b0);
        end
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("sole_requester", 4'b0001, 2'd0, 1'b1);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b1000;
        step();
        chk("wrap_grant3", 4'b1000, 2'd3, 1'b1);
        step();
        bus.req = 4'b0001;
        step();
        chk("wrap_release", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b1001;
        step();
        chk("wrap_to_0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0010;
        step();
        chk("ar_pre_grant", 4'b0010, 2'd1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mid_grant", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b0110;
        reset   = 1'b1;
        step();
        chk("ar_after_rel", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0000;
        step();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("lock_hold", 4'b0001, 2'd0, 1'b1);
        end
        bus.lock = 1'b0;
        step();
        chk("lock_forced_rel", 4'b0000, 2'd0, 1'b0);
        step();
        chk("lock_next_owner", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0000;
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_timeout();
        test_wrap();
        test_async_reset();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
